ctrl_pipe_hazard: RTL

// Consumer end of the decoded control bundle: carries RegDst/ALUSrc/MemtoReg/RegWrite/MemRead/

---
 rtl/ctrl_pipe_hazard_pkg.sv | 39 +++
 rtl/ctrl_pipe_hazard_if.sv | 49 ++++
 rtl/ctrl_pipe_hazard_fwd_unit.sv | 28 ++
 rtl/ctrl_pipe_hazard.sv | 140 ++++++++++++++
 4 files changed

// File: rtl/ctrl_pipe_hazard_pkg.sv
// Shared constants for the control pipeline: control-bundle bit offsets, ALUOp codes,
// forwarding select encodings and the bubble value.
// Bundle layout (MSB..LSB): {RegDst,ALUSrc,MemtoReg,RegWrite,MemRead,MemWrite,Branch,ALUOp}.
package ctrl_pipe_hazard_pkg;

  // Offsets of the single-bit controls above the ALUOp field (bit = ALUOP_W + offset)
  localparam int CB_REGDST   = 6;
  localparam int CB_ALUSRC   = 5;
  localparam int CB_MEMTOREG = 4;
  localparam int CB_REGWRITE = 3;
  localparam int CB_MEMREAD  = 2;
  localparam int CB_MEMWRITE = 1;
  localparam int CB_BRANCH   = 0;

  // EX/MEM bundle {MemtoReg,RegWrite,MemRead,MemWrite}
  localparam int MB_MEMTOREG = 3;
  localparam int MB_REGWRITE = 2;
  localparam int MB_MEMREAD  = 1;
  localparam int MB_MEMWRITE = 0;

  // MEM/WB bundle {MemtoReg,RegWrite}
  localparam int WB_MEMTOREG = 1;
  localparam int WB_REGWRITE = 0;

  // ALUOp codes
  localparam logic [2:0] ALUOP_RTYPE  = 3'b000;
  localparam logic [2:0] ALUOP_BRANCH = 3'b001;
  localparam logic [2:0] ALUOP_ITYPE  = 3'b010;
  localparam logic [2:0] ALUOP_ADDR   = 3'b011;

  // EX operand source selects
  localparam logic [1:0] FWD_REG = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // All-zero control word; sliced to the bundle width where used
  localparam logic [31:0] BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_hazard_if.sv
// Control-pipeline bus: ID-stage inputs, hazard/stall inputs and all pipeline control outputs.
// master = decoder/datapath side, slave = ctrl_pipe_hazard.
// Ports: id_valid/id_ctrl/id_rs/id_rt/id_rd, ex_branch_taken, mult_busy in; ex_*/mem_*/wb_*,
// pc_write, ifid_write, ifid_flush, fwd_a/fwd_b, stall_count out.
interface ctrl_pipe_hazard_if #(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3,
  parameter int CNT_W      = 16
);
  import ctrl_pipe_hazard_pkg::*;

  localparam int CTRL_W = 7 + ALUOP_W;

  logic                  id_valid;
  logic [CTRL_W-1:0]     id_ctrl;
  logic [REG_ADDR_W-1:0] id_rs;
  logic [REG_ADDR_W-1:0] id_rt;
  logic [REG_ADDR_W-1:0] id_rd;
  logic                  ex_branch_taken;
  logic                  mult_busy;

  logic [CTRL_W-1:0]     ex_ctrl;
  logic [REG_ADDR_W-1:0] ex_rs;
  logic [REG_ADDR_W-1:0] ex_rt;
  logic [REG_ADDR_W-1:0] ex_wreg;
  logic [3:0]            mem_ctrl;
  logic [REG_ADDR_W-1:0] mem_wreg;
  logic [1:0]            wb_ctrl;
  logic [REG_ADDR_W-1:0] wb_wreg;
  logic                  pc_write;
  logic                  ifid_write;
  logic                  ifid_flush;
  logic [1:0]            fwd_a;
  logic [1:0]            fwd_b;
  logic [CNT_W-1:0]      stall_count;

  modport master (
    output id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_branch_taken, mult_busy,
    input  ex_ctrl, ex_rs, ex_rt, ex_wreg, mem_ctrl, mem_wreg, wb_ctrl, wb_wreg,
    input  pc_write, ifid_write, ifid_flush, fwd_a, fwd_b, stall_count
  );

  modport slave (
    input  id_valid, id_ctrl, id_rs, id_rt, id_rd, ex_branch_taken, mult_busy,
    output ex_ctrl, ex_rs, ex_rt, ex_wreg, mem_ctrl, mem_wreg, wb_ctrl, wb_wreg,
    output pc_write, ifid_write, ifid_flush, fwd_a, fwd_b, stall_count
  );

endinterface

// File: rtl/ctrl_pipe_hazard_fwd_unit.sv
// EX operand forwarding compare for one source register.
// Latency: purely combinational.
// Backpressure: none; the select is re-evaluated every cycle.
// Ports: src (EX source reg), memRegWrite/memWreg, wbRegWrite/wbWreg in; fwdSel out.
module ctrl_pipe_hazard_fwd_unit
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src,
  input  logic                  memRegWrite,
  input  logic [REG_ADDR_W-1:0] memWreg,
  input  logic                  wbRegWrite,
  input  logic [REG_ADDR_W-1:0] wbWreg,
  output logic [1:0]            fwdSel
);

  // MEM is the younger producer, so it is checked first; r0 never forwards.
  always_comb begin
    fwdSel = FWD_REG;
    if (memRegWrite && (memWreg != '0) && (memWreg == src)) begin
      fwdSel = FWD_MEM;
    end else if (wbRegWrite && (wbWreg != '0) && (wbWreg == src)) begin
      fwdSel = FWD_WB;
    end
  end

endmodule

// File: rtl/ctrl_pipe_hazard.sv
// ID/EX, EX/MEM, MEM/WB control registers with load-use/multiplier stall, branch flush and forwarding.
// Latency: one cycle per stage; hazard and forwarding outputs are combinational.
// Backpressure: mult_busy holds ID/EX and bubbles EX/MEM; load-use bubbles ID/EX; both freeze PC and IF/ID.
// Ports: clk, rst_n (synchronous, active-low); bus (slave) carries ID inputs and all control outputs.
module ctrl_pipe_hazard
  import ctrl_pipe_hazard_pkg::*;
#(
  parameter int REG_ADDR_W = 5,
  parameter int ALUOP_W    = 3,
  parameter int CNT_W      = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  ctrl_pipe_hazard_if.slave   bus
);

  localparam int CTRL_W = 7 + ALUOP_W;

  logic [CTRL_W-1:0]     exCtrlQ, exCtrlD;
  logic [REG_ADDR_W-1:0] exRsQ, exRsD;
  logic [REG_ADDR_W-1:0] exRtQ, exRtD;
  logic [REG_ADDR_W-1:0] exWregQ, exWregD;
  logic [3:0]            memCtrlQ, memCtrlD;
  logic [REG_ADDR_W-1:0] memWregQ, memWregD;
  logic [1:0]            wbCtrlQ, wbCtrlD;
  logic [REG_ADDR_W-1:0] wbWregQ, wbWregD;
  logic [CNT_W-1:0]      stallCntQ, stallCntD;

  logic                  idUsesRt;
  logic [REG_ADDR_W-1:0] idWreg;
  logic                  loadUse;
  logic                  branchFlush;
  logic                  multStall;
  logic                  stallCycle;

  assign idUsesRt = bus.id_ctrl[ALUOP_W+CB_REGDST] | bus.id_ctrl[ALUOP_W+CB_MEMWRITE] |
                    bus.id_ctrl[ALUOP_W+CB_BRANCH];
  assign idWreg   = bus.id_ctrl[ALUOP_W+CB_REGDST] ? bus.id_rd : bus.id_rt;

  assign loadUse = exCtrlQ[ALUOP_W+CB_MEMREAD] && (exWregQ != '0) &&
                   ((exWregQ == bus.id_rs) || (idUsesRt && (exWregQ == bus.id_rt)));

  // A taken branch overrides both stall sources: the wrong-path work they would hold is discarded.
  assign branchFlush = exCtrlQ[ALUOP_W+CB_BRANCH] & bus.ex_branch_taken;
  assign multStall   = bus.mult_busy & ~branchFlush;
  assign stallCycle  = ~branchFlush & (bus.mult_busy | loadUse);

  assign bus.pc_write   = rst_n & ~stallCycle;
  assign bus.ifid_write = rst_n & ~stallCycle;
  assign bus.ifid_flush = ~rst_n | branchFlush;

  always_comb begin
    exCtrlD   = BUBBLE[CTRL_W-1:0];
    exRsD     = '0;
    exRtD     = '0;
    exWregD   = '0;
    memCtrlD  = exCtrlQ[ALUOP_W+CB_MEMTOREG -: 4];
    memWregD  = exWregQ;
    wbCtrlD   = memCtrlQ[MB_MEMTOREG -: 2];
    wbWregD   = memWregQ;
    stallCntD = stallCntQ;

    if (branchFlush) begin
      // ID/EX takes the bubble defaults
    end else if (bus.mult_busy) begin
      exCtrlD = exCtrlQ;
      exRsD   = exRsQ;
      exRtD   = exRtQ;
      exWregD = exWregQ;
    end else if (!loadUse && bus.id_valid) begin
      exCtrlD = bus.id_ctrl;
      exRsD   = bus.id_rs;
      exRtD   = bus.id_rt;
      exWregD = idWreg;
    end

    // The instruction held in EX must not also appear in MEM while the multiplier runs
    if (multStall) begin
      memCtrlD = '0;
      memWregD = '0;
    end

    if (stallCycle && (stallCntQ != '1)) begin
      stallCntD = stallCntQ + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      exCtrlQ   <= '0;
      exRsQ     <= '0;
      exRtQ     <= '0;
      exWregQ   <= '0;
      memCtrlQ  <= '0;
      memWregQ  <= '0;
      wbCtrlQ   <= '0;
      wbWregQ   <= '0;
      stallCntQ <= '0;
    end else begin
      exCtrlQ   <= exCtrlD;
      exRsQ     <= exRsD;
      exRtQ     <= exRtD;
      exWregQ   <= exWregD;
      memCtrlQ  <= memCtrlD;
      memWregQ  <= memWregD;
      wbCtrlQ   <= wbCtrlD;
      wbWregQ   <= wbWregD;
      stallCntQ <= stallCntD;
    end
  end

  ctrl_pipe_hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) fwdA (
    .src         (exRsQ),
    .memRegWrite (memCtrlQ[MB_REGWRITE]),
    .memWreg     (memWregQ),
    .wbRegWrite  (wbCtrlQ[WB_REGWRITE]),
    .wbWreg      (wbWregQ),
    .fwdSel      (bus.fwd_a)
  );

  ctrl_pipe_hazard_fwd_unit #(.REG_ADDR_W(REG_ADDR_W)) fwdB (
    .src         (exRtQ),
    .memRegWrite (memCtrlQ[MB_REGWRITE]),
    .memWreg     (memWregQ),
    .wbRegWrite  (wbCtrlQ[WB_REGWRITE]),
    .wbWreg      (wbWregQ),
    .fwdSel      (bus.fwd_b)
  );

  assign bus.ex_ctrl     = exCtrlQ;
  assign bus.ex_rs       = exRsQ;
  assign bus.ex_rt       = exRtQ;
  assign bus.ex_wreg     = exWregQ;
  assign bus.mem_ctrl    = memCtrlQ;
  assign bus.mem_wreg    = memWregQ;
  assign bus.wb_ctrl     = wbCtrlQ;
  assign bus.wb_wreg     = wbWregQ;
  assign bus.stall_count = stallCntQ;

endmodule
